// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
package serial_adder_ctrl_pkg;

    localparam int SA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        SA_IDLE = 2'd0,
        SA_RUN  = 2'd1,
        SA_DONE = 2'd2
    } sa_state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a client and serial_adder_ctrl.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (output start, op_sub, a, b, cin,
                    input  sum, cout, busy, done, ovf);
    modport slave  (input  start, op_sub, a, b, cin,
                    output sum, cout, busy, done, ovf);
`else
    modport master (output start, op_sub, a, b, cin,
                    input  sum, cout, busy, done);
    modport slave  (input  start, op_sub, a, b, cin,
                    output sum, cout, busy, done);
`endif

endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder shared across every bit position by the serial controller.
module full_adder (
    output logic sum,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full_adder walked LSB-first over WIDTH bits.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow flag.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    serial_adder_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    sa_state_t        state;
    sa_state_t        state_nxt;
    logic             load;
    logic             last;
    logic             busy;
    logic             done;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout_q;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (fa_sum, fa_cout, a_sr[0], b_sr[0], carry);

    always_ff @(posedge clk) begin
        if (rst) state <= SA_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        last      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            SA_IDLE: begin
                if (bus.start) begin
                    state_nxt = SA_RUN;
                    load      = 1'b1;
                end
            end
            SA_RUN: begin
                busy = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = SA_DONE;
                    last      = 1'b1;
                end
            end
            SA_DONE: begin
                done = 1'b1;
                if (bus.start) begin
                    state_nxt = SA_RUN;
                    load      = 1'b1;
                end else begin
                    state_nxt = SA_IDLE;
                end
            end
            default: state_nxt = SA_IDLE;
        endcase
    end

    // The newest sum bit enters at the MSB, so after WIDTH steps bit 0 holds the first one.
    assign res_nxt = {fa_sum, res_sr};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (load) begin
            a_sr  <= bus.a;
            b_sr  <= bus.op_sub ? ~bus.b : bus.b;
            carry <= bus.op_sub | bus.cin;
            cnt   <= '0;
        end else if (state == SA_RUN) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr <= res_nxt[WIDTH-1:1];
            carry  <= fa_cout;
            if (last) begin
                sum_q  <= res_nxt;
                cout_q <= fa_cout;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;

    // On the last bit the carry flop still holds the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst)       ovf_q <= 1'b0;
        else if (last) ovf_q <= carry ^ fa_cout;
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.busy = busy;
    assign bus.done = done;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8: vector table plus
// hand-written sequences for ignored start, mid-run reset and back-to-back ops.
module tb_serial_adder_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_adder_ctrl_if #(.WIDTH(8)) bus ();

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drives a request for exactly one edge (E0) and returns just after it.
    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b,
                                  input logic sub, input logic cin);
        bus.a      = a;
        bus.b      = b;
        bus.op_sub = sub;
        bus.cin    = cin;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    // Latency counts edges from E0 inclusive until done is seen; bounded.
    task automatic wait_done(input int start_lat, output int lat, output int busy_cnt);
        lat      = start_lat;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int busy_cnt;

        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus.cin    = 1'b0;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'h07, 8'h05, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[8] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[9] = '{8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};

        tick();
        tick();
        rst = 1'b0;
        check_output("reset_sum",  bus.sum,  8'h00);
        check_output("reset_cout", bus.cout, 1'b0);
        check_output("reset_busy", bus.busy, 1'b0);
        check_output("reset_done", bus.done, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
        check_output("reset_ovf",  bus.ovf,  1'b0);
`endif
        tick();

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
            wait_done(1, lat, busy_cnt);
            check_output($sformatf("vec%0d_latency", i), lat, 9);
            check_output($sformatf("vec%0d_busy_cycles", i), busy_cnt, 8);
            check_output($sformatf("vec%0d_busy_at_done", i), bus.busy, 1'b0);
            check_output($sformatf("vec%0d_sum", i), bus.sum, vecs[i].sum);
            check_output($sformatf("vec%0d_cout", i), bus.cout, vecs[i].cout);
`ifdef SERIAL_ADD_OVF_EN
            check_output($sformatf("vec%0d_ovf", i), bus.ovf, vecs[i].ovf);
`endif
            tick();
            check_output($sformatf("vec%0d_done_fall", i), bus.done, 1'b0);
            check_output($sformatf("vec%0d_idle_busy", i), bus.busy, 1'b0);
            check_output($sformatf("vec%0d_sum_held", i), bus.sum, vecs[i].sum);
        end

        // start raised during the 3rd RUN cycle must be dropped, not queued.
        apply_stimulus(8'h0F, 8'h01, 1'b0, 1'b0);
        tick();
        tick();
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(4, lat, busy_cnt);
        check_output("ignore_latency", lat, 9);
        check_output("ignore_sum", bus.sum, 8'h10);
        check_output("ignore_cout", bus.cout, 1'b0);
        tick();
        check_output("ignore_no_restart", bus.busy, 1'b0);
        tick();
        check_output("ignore_still_idle", bus.busy, 1'b0);

        // Reset on the 4th RUN cycle discards the op and clears held results.
        apply_stimulus(8'hFF, 8'h01, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        check_output("midrun_busy_before", bus.busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("midrun_rst_busy", bus.busy, 1'b0);
        check_output("midrun_rst_sum",  bus.sum,  8'h00);
        check_output("midrun_rst_done", bus.done, 1'b0);
        check_output("midrun_rst_cout", bus.cout, 1'b0);

        // Reset and start together: reset wins.
        bus.a     = 8'h33;
        bus.b     = 8'h11;
        bus.start = 1'b1;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        check_output("rst_start_busy", bus.busy, 1'b0);
        tick();
        check_output("rst_start_still_idle", bus.busy, 1'b0);

        apply_stimulus(8'h01, 8'h02, 1'b0, 1'b0);
        wait_done(1, lat, busy_cnt);
        check_output("post_rst_latency", lat, 9);
        check_output("post_rst_sum", bus.sum, 8'h03);
        tick();

        // Back-to-back: start held through the DONE cycle launches the next op.
        apply_stimulus(8'h0F, 8'h01, 1'b0, 1'b0);
        wait_done(1, lat, busy_cnt);
        check_output("b2b_first_latency", lat, 9);
        check_output("b2b_first_sum", bus.sum, 8'h10);
        bus.a      = 8'h10;
        bus.b      = 8'h20;
        bus.op_sub = 1'b0;
        bus.cin    = 1'b0;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        check_output("b2b_restart_busy", bus.busy, 1'b1);
        check_output("b2b_restart_done", bus.done, 1'b0);
        check_output("b2b_sum_held", bus.sum, 8'h10);
        wait_done(1, lat, busy_cnt);
        check_output("b2b_second_gap", lat, 9);
        check_output("b2b_second_sum", bus.sum, 8'h30);
        check_output("b2b_second_cout", bus.cout, 1'b0);
        tick();
        check_output("b2b_done_fall", bus.done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
